// File: rtl/pair_issue_sched_pkg.sv
// pair_issue_sched_pkg: opcode constants, FSM encoding and decode helpers shared by the pair scheduler
package pair_issue_sched_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic {PAIR = 1'b0, SECOND = 1'b1} state_t;

  // Register written by an instruction; 0 means no write ($0 writes are discarded anyway).
  // Opcodes 0x08-0x0F are the immediate ALU group, which all write rt.
  function automatic logic [4:0] dest_of(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return (op == OP_RTYPE && i[5:0] != FUNCT_JR) ? i[15:11] :
           (op[5:3] == 3'b001 || op == OP_LW)      ? i[20:16] :
           (op == OP_JAL)                          ? 5'd31    : 5'd0;
  endfunction

  function automatic logic reads_rt(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE;
  endfunction

  function automatic logic is_mem(input logic [31:0] i);
    return i[31:26] == OP_LW || i[31:26] == OP_SW;
  endfunction

endpackage

// File: rtl/pair_issue_sched_hazard_detect.sv
// pair_hazard_detect: combinational intra-pair conflict reasons for a fetched instruction pair
// Ports: instr_1/instr_2 in (older/younger instruction); raw, waw, bothmem out (conflict reasons).
module pair_hazard_detect
  import pair_issue_sched_pkg::*;
(
  input  logic [31:0] instr_1,
  input  logic [31:0] instr_2,
  output logic        raw,
  output logic        waw,
  output logic        bothmem
);
  logic [4:0] dest_1, dest_2, rs_2, rt_2;
  always_comb begin
    dest_1  = dest_of(instr_1);
    dest_2  = dest_of(instr_2);
    rs_2    = instr_2[25:21];
    rt_2    = instr_2[20:16];
    // rs is treated as always read; rt only for formats that actually source it.
    raw     = dest_1 != 5'd0 && (dest_1 == rs_2 || (reads_rt(instr_2) && dest_1 == rt_2));
    waw     = dest_1 != 5'd0 && dest_1 == dest_2;
    bothmem = is_mem(instr_1) && is_mem(instr_2);
  end
endmodule

// File: rtl/pair_issue_sched.sv
// pair_issue_sched: dual-issue pair scheduler splitting conflicting pairs over two cycles
// Ports: clk, rst (async active-low); fetch side pair_valid, instr_1/2, pc_1, flush_second;
// control stall_in, squash; hold (comb PC freeze); registered issue slots A/B; split_active, split_count.
module pair_issue_sched
  import pair_issue_sched_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pair_valid,
  input  logic [DW-1:0] instr_1,
  input  logic [DW-1:0] instr_2,
  input  logic [AW-1:0] pc_1,
  input  logic          flush_second,
  input  logic          stall_in,
  input  logic          squash,
  output logic          hold,
  output logic          issue_valid_a,
  output logic [DW-1:0] issue_instr_a,
  output logic [AW-1:0] issue_pc_a,
  output logic          issue_valid_b,
  output logic [DW-1:0] issue_instr_b,
  output logic [AW-1:0] issue_pc_b,
  output logic          split_active,
  output logic [CW-1:0] split_count
);
  state_t        state;
  logic [DW-1:0] buf_instr;
  logic [AW-1:0] buf_pc;
  logic [AW-1:0] pc_2;
  logic          raw, waw, bothmem, conflict;

  pair_hazard_detect u_hazard (
    .instr_1 (instr_1[31:0]),
    .instr_2 (instr_2[31:0]),
    .raw     (raw),
    .waw     (waw),
    .bothmem (bothmem)
  );

  assign pc_2         = pc_1 + AW'(1);
  assign conflict     = pair_valid & ~flush_second & (raw | waw | bothmem);
  // Conflict only matters in PAIR; in SECOND the re-presented pair is ignored.
  assign hold         = ~squash & (stall_in | (state == PAIR & conflict));
  assign split_active = state == SECOND;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= PAIR;
      buf_instr     <= '0;
      buf_pc        <= '0;
      split_count   <= '0;
      issue_valid_a <= 1'b0;
      issue_instr_a <= '0;
      issue_pc_a    <= '0;
      issue_valid_b <= 1'b0;
      issue_instr_b <= '0;
      issue_pc_b    <= '0;
    end else if (squash) begin
      state         <= PAIR;
      buf_instr     <= '0;
      buf_pc        <= '0;
      issue_valid_a <= 1'b0;
      issue_valid_b <= 1'b0;
    end else if (!stall_in) begin
      if (state == SECOND) begin
        state         <= PAIR;
        issue_valid_a <= 1'b1;
        issue_instr_a <= buf_instr;
        issue_pc_a    <= buf_pc;
        issue_valid_b <= 1'b0;
      end else begin
        issue_valid_a <= pair_valid;
        issue_instr_a <= instr_1;
        issue_pc_a    <= pc_1;
        issue_valid_b <= pair_valid & ~flush_second & ~conflict;
        issue_instr_b <= instr_2;
        issue_pc_b    <= pc_2;
        if (conflict) begin
          state       <= SECOND;
          buf_instr   <= instr_2;
          buf_pc      <= pc_2;
          split_count <= (&split_count) ? split_count : split_count + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pair_issue_sched.sv
// tb_pair_issue_sched: directed self-checking bench for pair_issue_sched
module tb_pair_issue_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        pair_valid, flush_second, stall_in, squash;
  logic [31:0] instr_1, instr_2;
  logic [9:0]  pc_1;
  logic        hold, issue_valid_a, issue_valid_b, split_active;
  logic [31:0] issue_instr_a, issue_instr_b;
  logic [9:0]  issue_pc_a, issue_pc_b;
  logic [15:0] split_count;
  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] ADD3  = 32'h00221820;
  localparam logic [31:0] ADD5  = 32'h00C72820;
  localparam logic [31:0] RAW2  = 32'h00612020;
  localparam logic [31:0] WAW2  = 32'h00C71820;
  localparam logic [31:0] LW8   = 32'h8D280000;
  localparam logic [31:0] SW10  = 32'hAD6A0004;
  localparam logic [31:0] ADD0  = 32'h00220020;
  localparam logic [31:0] RD0   = 32'h00012020;
  localparam logic [31:0] JR31  = 32'h03E00008;
  localparam logic [31:0] USE31 = 32'h03E12020;

  pair_issue_sched dut (
    .clk(clk), .rst(rst), .pair_valid(pair_valid), .instr_1(instr_1), .instr_2(instr_2),
    .pc_1(pc_1), .flush_second(flush_second), .stall_in(stall_in), .squash(squash),
    .hold(hold), .issue_valid_a(issue_valid_a), .issue_instr_a(issue_instr_a),
    .issue_pc_a(issue_pc_a), .issue_valid_b(issue_valid_b), .issue_instr_b(issue_instr_b),
    .issue_pc_b(issue_pc_b), .split_active(split_active), .split_count(split_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [9:0] pc, input logic fs);
    pair_valid = pv; instr_1 = i1; instr_2 = i2; pc_1 = pc; flush_second = fs;
  endtask

  task automatic test_reset();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b000) begin nerr++; $display("FAIL reset_valids got %b want 000", {issue_valid_a, issue_valid_b, split_active}); end
    nvec++; if ({issue_instr_a, issue_pc_a, issue_instr_b, issue_pc_b} !== 84'h0) begin nerr++; $display("FAIL reset_data got %h want 0", {issue_instr_a, issue_pc_a, issue_instr_b, issue_pc_b}); end
    nvec++; if (split_count !== 16'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", split_count); end
  endtask

  task automatic test_independent();
    drive(1'b1, ADD3, ADD5, 10'h010, 1'b0);
    #1;
    nvec++; if (hold !== 1'b0) begin nerr++; $display("FAIL indep_hold got %b want 0", hold); end
    step();
    nvec++; if ({issue_valid_a, issue_valid_b} !== 2'b11) begin nerr++; $display("FAIL indep_valids got %b want 11", {issue_valid_a, issue_valid_b}); end
    nvec++; if (issue_pc_a !== 10'h010 || issue_pc_b !== 10'h011) begin nerr++; $display("FAIL indep_pcs got %h/%h want 010/011", issue_pc_a, issue_pc_b); end
    nvec++; if (issue_instr_a !== ADD3 || issue_instr_b !== ADD5) begin nerr++; $display("FAIL indep_instrs got %h/%h want %h/%h", issue_instr_a, issue_instr_b, ADD3, ADD5); end
    nvec++; if (split_count !== 16'd0 || split_active !== 1'b0) begin nerr++; $display("FAIL indep_count got %0d/%b want 0/0", split_count, split_active); end
  endtask

  task automatic test_split(input string nm, input logic [31:0] i1, input logic [31:0] i2,
                            input logic [9:0] pc, input logic [9:0] pc2, input logic [15:0] cnt);
    drive(1'b1, i1, i2, pc, 1'b0);
    #1;
    nvec++; if (hold !== 1'b1) begin nerr++; $display("FAIL %s_hold1 got %b want 1", nm, hold); end
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b101 || issue_instr_a !== i1 || issue_pc_a !== pc) begin nerr++; $display("FAIL %s_first got v=%b%b sa=%b %h@%h want 101 %h@%h", nm, issue_valid_a, issue_valid_b, split_active, issue_instr_a, issue_pc_a, i1, pc); end
    nvec++; if (hold !== 1'b0) begin nerr++; $display("FAIL %s_hold2 got %b want 0", nm, hold); end
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b100 || issue_instr_a !== i2 || issue_pc_a !== pc2) begin nerr++; $display("FAIL %s_second got v=%b%b sa=%b %h@%h want 100 %h@%h", nm, issue_valid_a, issue_valid_b, split_active, issue_instr_a, issue_pc_a, i2, pc2); end
    nvec++; if (split_count !== cnt) begin nerr++; $display("FAIL %s_count got %0d want %0d", nm, split_count, cnt); end
    drive(1'b0, 32'h0, 32'h0, 10'h0, 1'b0);
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b000) begin nerr++; $display("FAIL %s_idle got %b want 000", nm, {issue_valid_a, issue_valid_b, split_active}); end
  endtask

  task automatic test_flush_second();
    drive(1'b1, ADD3, RAW2, 10'h040, 1'b1);
    #1;
    nvec++; if (hold !== 1'b0) begin nerr++; $display("FAIL flush_hold got %b want 0", hold); end
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b100 || issue_instr_a !== ADD3) begin nerr++; $display("FAIL flush_issue got %b %h want 100 %h", {issue_valid_a, issue_valid_b, split_active}, issue_instr_a, ADD3); end
    nvec++; if (split_count !== 16'd3) begin nerr++; $display("FAIL flush_count got %0d want 3", split_count); end
  endtask

  task automatic test_no_write();
    drive(1'b1, ADD0, RD0, 10'h050, 1'b0);
    #1;
    nvec++; if (hold !== 1'b0) begin nerr++; $display("FAIL zero_dest_hold got %b want 0", hold); end
    step();
    nvec++; if ({issue_valid_a, issue_valid_b} !== 2'b11) begin nerr++; $display("FAIL zero_dest_valids got %b want 11", {issue_valid_a, issue_valid_b}); end
    drive(1'b1, JR31, USE31, 10'h060, 1'b0);
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b110) begin nerr++; $display("FAIL jr_valids got %b want 110", {issue_valid_a, issue_valid_b, split_active}); end
  endtask

  task automatic test_wrap();
    drive(1'b1, ADD3, ADD5, 10'h3FF, 1'b0);
    step();
    nvec++; if (issue_pc_a !== 10'h3FF || issue_pc_b !== 10'h000 || issue_valid_b !== 1'b1) begin nerr++; $display("FAIL wrap got %h/%h vb=%b want 3ff/000 1", issue_pc_a, issue_pc_b, issue_valid_b); end
  endtask

  task automatic test_squash();
    drive(1'b1, ADD3, RAW2, 10'h070, 1'b0);
    step();
    nvec++; if (split_active !== 1'b1) begin nerr++; $display("FAIL squash_enter got %b want 1", split_active); end
    stall_in = 1'b1; squash = 1'b1;
    #1;
    nvec++; if (hold !== 1'b0) begin nerr++; $display("FAIL squash_hold got %b want 0", hold); end
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b000) begin nerr++; $display("FAIL squash_out got %b want 000", {issue_valid_a, issue_valid_b, split_active}); end
    nvec++; if (split_count !== 16'd4) begin nerr++; $display("FAIL squash_count got %0d want 4", split_count); end
    stall_in = 1'b0; squash = 1'b0;
    drive(1'b1, ADD3, ADD5, 10'h080, 1'b0);
    step();
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b110 || issue_pc_a !== 10'h080) begin nerr++; $display("FAIL squash_resume got %b %h want 110 080", {issue_valid_a, issue_valid_b, split_active}, issue_pc_a); end
  endtask

  task automatic test_stall_reset();
    drive(1'b1, ADD3, RAW2, 10'h090, 1'b0);
    step();
    stall_in = 1'b1;
    drive(1'b1, ADD5, ADD3, 10'h100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      nvec++; if (hold !== 1'b1) begin nerr++; $display("FAIL stall_hold%0d got %b want 1", k, hold); end
      step();
      nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b101 || issue_instr_a !== ADD3 || issue_pc_a !== 10'h090 || split_count !== 16'd5) begin nerr++; $display("FAIL stall_frozen%0d got %b %h@%h cnt=%0d want 101 %h@090 cnt=5", k, {issue_valid_a, issue_valid_b, split_active}, issue_instr_a, issue_pc_a, split_count, ADD3); end
    end
    #2 rst = 1'b0;
    #1;
    nvec++; if ({issue_valid_a, issue_valid_b, split_active} !== 3'b000 || split_count !== 16'd0 || issue_instr_a !== 32'h0) begin nerr++; $display("FAIL async_reset got %b cnt=%0d %h want 000 cnt=0 0", {issue_valid_a, issue_valid_b, split_active}, split_count, issue_instr_a); end
    stall_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 10'h0, 1'b0);
    #1;
    nvec++; if (hold !== 1'b0) begin nerr++; $display("FAIL reset_hold got %b want 0", hold); end
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; squash = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 10'h0, 1'b0);
    #12;
    test_reset();
    rst = 1'b1;
    step();
    test_independent();
    test_split("raw", ADD3, RAW2, 10'h010, 10'h011, 16'd1);
    test_split("bothmem", LW8, SW10, 10'h020, 10'h021, 16'd2);
    test_split("waw", ADD3, WAW2, 10'h030, 10'h031, 16'd3);
    test_flush_second();
    test_no_write();
    test_wrap();
    test_squash();
    test_stall_reset();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout after 100000 time units");
    $fatal(1, "timeout");
  end
endmodule
